// File: rtl/logic_sweep_checker_if.sv
// Handshake/result bundle between the sweep checker and the logic blocks under check.
interface logic_sweep_checker_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             f_a;
  logic             f_b;
  logic [WIDTH-1:0] x;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH:0]   mismatch_cnt;
  logic             first_fail_valid;
  logic [WIDTH-1:0] first_fail_x;

  modport master (
    output start, f_a, f_b,
    input  x, busy, done, pass, mismatch_cnt, first_fail_valid, first_fail_x
  );

  modport slave (
    input  start, f_a, f_b,
    output x, busy, done, pass, mismatch_cnt, first_fail_valid, first_fail_x
  );
endinterface

// File: rtl/logic_sweep_checker.sv
// Sweeps x over all codes, compares f_a/f_b at the end of each dwell, reports pass/fail.
// Optional LOGIC_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatching code.
module logic_sweep_checker #(
  parameter int WIDTH = 4,
  parameter int DWELL = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_sweep_checker_if.slave bus
);
  localparam int TW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [TW-1:0] LAST_T = TW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    timer;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH:0]   cnt_q;
  logic             ffv_q;
  logic [WIDTH-1:0] ffx_q;
  logic             pass_q;
  logic             busy_c, done_c;
  logic             accept, sample, mism, last_code, end_sweep;

  assign accept    = bus.start && (state != RUN);
  assign sample    = (state == RUN) && (timer == LAST_T);
  assign mism      = sample && (bus.f_a != bus.f_b);
  assign last_code = &x_q;
`ifdef LOGIC_SWEEP_STOP_ON_FAIL_EN
  assign end_sweep = sample && (last_code || mism);
`else
  assign end_sweep = sample && last_code;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nxt = RUN;
      RUN:        if (end_sweep) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state == RUN);
    done_c = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer  <= '0;
      x_q    <= '0;
      cnt_q  <= '0;
      ffv_q  <= 1'b0;
      ffx_q  <= '0;
      pass_q <= 1'b0;
    end else if (accept) begin
      timer  <= '0;
      x_q    <= '0;
      cnt_q  <= '0;
      ffv_q  <= 1'b0;
      ffx_q  <= '0;
      pass_q <= 1'b0;
    end else if (state == RUN) begin
      if (sample) begin
        timer <= '0;
        if (mism) begin
          cnt_q <= cnt_q + (WIDTH+1)'(1);
          if (!ffv_q) begin
            ffv_q <= 1'b1;
            ffx_q <= x_q;
          end
        end
        // x freezes on the final sampled code so it names the last vector checked
        if (end_sweep) pass_q <= (cnt_q == '0) && !mism;
        else           x_q    <= x_q + WIDTH'(1);
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end

  assign bus.x                = x_q;
  assign bus.busy             = busy_c;
  assign bus.done             = done_c;
  assign bus.pass             = pass_q;
  assign bus.mismatch_cnt     = cnt_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.first_fail_x     = ffx_q;
endmodule

// File: tb/tb_logic_sweep_checker.sv
// Randomized bench for logic_sweep_checker against a per-sweep outcome model.
module tb_logic_sweep_checker;
  localparam int WIDTH  = 4;
  localparam int NCODES = 1 << WIDTH;
`ifdef LOGIC_SWEEP_STOP_ON_FAIL_EN
  localparam int DWELL = 2;
  localparam bit STOP  = 1'b1;
`else
  localparam int DWELL = 10;
  localparam bit STOP  = 1'b0;
`endif

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  logic [NCODES-1:0] fault_mask = '0;
  logic [NCODES-1:0] fa_tbl = '0;

  logic_sweep_checker_if #(.WIDTH(WIDTH)) bus ();

  logic_sweep_checker #(.WIDTH(WIDTH), .DWELL(DWELL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 if (clk_en) clk = ~clk;

  // Stand-in for the two logic blocks: f_b deviates from f_a exactly on masked codes.
  assign bus.f_a = fa_tbl[bus.x];
  assign bus.f_b = fa_tbl[bus.x] ^ fault_mask[bus.x];

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Outcome of one sweep from the fault set alone.
  task automatic model(input logic [NCODES-1:0] m, output int cnt, output int ffv,
                       output int ffx, output int last);
    cnt = 0; ffv = 0; ffx = 0; last = NCODES - 1;
    for (int c = 0; c < NCODES; c++) begin
      if (m[c]) begin
        cnt++;
        if (ffv == 0) begin ffv = 1; ffx = c; end
        if (STOP) begin last = c; break; end
      end
    end
  endtask

  task automatic run_sweep(input string tag, input logic [NCODES-1:0] m, input bit poke);
    int cnt, ffv, ffx, last, cyc, ex;
    bit poked;
    model(m, cnt, ffv, ffx, last);
    fault_mask = m;
    for (int c = 0; c < NCODES; c++) fa_tbl[c] = 1'($urandom_range(0, 1));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, ":done_drop"}, int'(bus.done), 0);
    chk({tag, ":pass_drop"}, int'(bus.pass), 0);
    cyc = 0;
    poked = 1'b0;
    while (!bus.done && cyc <= NCODES * DWELL + 4) begin
      ex = cyc / DWELL;
      if (ex > last) ex = last;
      chk({tag, ":x_step"}, int'(bus.x), ex);
      chk({tag, ":busy"}, int'(bus.busy), 1);
      if (poke && !poked && bus.x == 3) begin
        bus.start = 1'b1;
        poked = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk({tag, ":done_latency"}, cyc, (last + 1) * DWELL);
    chk({tag, ":done"}, int'(bus.done), 1);
    chk({tag, ":busy_end"}, int'(bus.busy), 0);
    chk({tag, ":pass"}, int'(bus.pass), int'(cnt == 0));
    chk({tag, ":mismatch_cnt"}, int'(bus.mismatch_cnt), cnt);
    chk({tag, ":ff_valid"}, int'(bus.first_fail_valid), ffv);
    if (ffv != 0) chk({tag, ":ff_x"}, int'(bus.first_fail_x), ffx);
    chk({tag, ":x_final"}, int'(bus.x), last);
    repeat (3) @(negedge clk);
    chk({tag, ":done_hold"}, int'(bus.done), 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ":x"}, int'(bus.x), 0);
    chk({tag, ":busy"}, int'(bus.busy), 0);
    chk({tag, ":done"}, int'(bus.done), 0);
    chk({tag, ":pass"}, int'(bus.pass), 0);
    chk({tag, ":cnt"}, int'(bus.mismatch_cnt), 0);
    chk({tag, ":ffv"}, int'(bus.first_fail_valid), 0);
    chk({tag, ":ffx"}, int'(bus.first_fail_x), 0);
  endtask

  initial begin
    int guard;
    logic [NCODES-1:0] m;
    bus.start = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("rst_noclk");
    #10 clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk_reset_vals("idle20");

    run_sweep("clean", '0, 1'b0);
    m = '0; m[5] = 1'b1; m[9] = 1'b1;
    run_sweep("x5x9", m, 1'b1);
    run_sweep("allfail", '1, 1'b0);
    m = '0; m[4] = 1'b1;
    run_sweep("x4only", m, 1'b0);

    // asynchronous abort mid-sweep
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    fault_mask = '0;
    guard = 0;
    while (bus.x != 7 && guard < NCODES * DWELL) begin
      @(negedge clk);
      guard++;
    end
    chk("midrst:reach_x7", int'(bus.x), 7);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk_reset_vals("midrst_idle");
    run_sweep("clean_again", '0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      m = NCODES'($urandom & $urandom & $urandom);
      run_sweep($sformatf("rand%0d", r), m, r[0]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/logic_sweep_checker.md
Name: logic_sweep_checker

Overview:
Self-checking sweep stage that sits around the combinational 4-input logic blocks. It drives the shared input vector x through every code from 0 to 2^WIDTH-1, holding each code for a programmable dwell time. At the end of each dwell it compares the two implementations' outputs (multiplexer-based f_a and gate-based f_b). It accumulates the mismatch count, records the first failing vector, and reports pass/fail when the sweep completes.

Parameters:
WIDTH, 4, width of the swept input vector x; sweep length is 2^WIDTH codes.
DWELL, 10, clock cycles each code is held; legal range is 1 or more; f is sampled on the last cycle of the dwell.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle request to begin a sweep; honoured only when not busy.
f_a  input  1  output of the multiplexer implementation under check.
f_b  input  1  output of the gate implementation under check.
x  output  WIDTH  vector driven to both implementations.
busy  output  1  high while a sweep is in progress.
done  output  1  high from sweep completion until the next accepted start.
pass  output  1  high with done when mismatch_cnt == 0.
mismatch_cnt  output  WIDTH+1  number of codes where f_a != f_b.
first_fail_valid  output  1  high once any mismatch has been recorded in the current sweep.
first_fail_x  output  WIDTH  x value of the first mismatch; meaningful only when first_fail_valid is high.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values (immediate on rst_n low, independent of clk): x=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail_valid=0, first_fail_x=0, FSM=IDLE, dwell timer=0.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE, with start=1 at a rising edge:
  - Clear x, mismatch_cnt, first_fail_valid, first_fail_x, done and pass.
  - Set busy=1, timer=0, go to RUN.
  - x=0 is valid from that edge onward.
- RUN:
  - The timer increments each cycle.
  - When timer == DWELL-1, sample f_a and f_b at that edge.
  - On mismatch: mismatch_cnt increments. If first_fail_valid=0, capture first_fail_x=x and set first_fail_valid=1.
  - At the same edge, if x == 2^WIDTH-1, go to DONE: busy=0, done=1, pass=(final count==0). x holds at all-ones.
  - Otherwise x increments and timer resets to 0.
- Latency:
  - Start accepted at edge k.
  - First sample at edge k+DWELL.
  - done rises at edge k+2^WIDTH*DWELL (160 cycles at defaults).
- start while busy=1 is ignored, with no effect on state or outputs.
- start in DONE begins a new sweep; done and pass drop at the accepting edge.
- mismatch_cnt is WIDTH+1 bits, so the all-codes-fail case (2^WIDTH) is representable without wrap.
- DWELL=1: a sample every cycle, with x stepping every cycle.
- f_a and f_b are treated as settled by the last dwell cycle. The block samples nothing earlier in the dwell.
- rst_n low mid-sweep aborts immediately to the reset values. After release the FSM stays in IDLE until start.

Optional Feature:
Macro name: LOGIC_SWEEP_STOP_ON_FAIL_EN.
- Defined: the first mismatch ends the sweep at that sampling edge.
  - FSM goes to DONE: busy=0, done=1, pass=0.
  - mismatch_cnt=1; x holds the failing vector, equal to first_fail_x.
  - A sweep with no mismatch behaves exactly as when undefined.
- Undefined: the sweep always covers all 2^WIDTH codes and counts every mismatch.

Test Plan:
1. Reset check: assert rst_n=0 with clk stopped -> all outputs at reset values immediately. Release with no start for 20 cycles -> x=0, busy=0, done=0.
2. Clean sweep: defaults, f_b tied to f_a, pulse start -> x steps 0..15 every 10 cycles; done=1 exactly 160 cycles after start; pass=1, mismatch_cnt=0, x=15, busy=0.
3. Injected faults: invert f_b only while x==5 and x==9 -> done with mismatch_cnt=2, first_fail_valid=1, first_fail_x=5, pass=0.
4. Start handling and total failure: pulse start again at x==3 mid-sweep -> ignored, sweep finishes normally. After done, start with f_b=~f_a constant -> mismatch_cnt=16, first_fail_x=0, pass=0.
5. Mid-sweep reset: pulse rst_n low while x==7, between clock edges -> outputs reset asynchronously. After release, idle until start; the next full sweep reproduces scenario 2.
6. Stop-on-fail (LOGIC_SWEEP_STOP_ON_FAIL_EN defined, DWELL=2): mismatch only at x==4 -> done at the x==4 sample edge (10 cycles after start), mismatch_cnt=1, x=4, first_fail_x=4, pass=0.
